// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT magnitude store: state encoding,
// default frame/data sizes and the magnitude-width helper.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int N_POINTS_DEF = 1024;
  localparam int DATA_W_DEF   = 16;

  function automatic int mag_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage squared-magnitude pipeline: stage 1 squares re and im, stage 2 sums.
// Valid and bin index travel alongside the data.
module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 10,
  parameter int MAG_W  = mag_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_im,
  input  logic [ADDR_W-1:0] i_idx,
  output logic              o_s1_valid,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_idx,
  output logic [MAG_W-1:0]  o_mag
);

  localparam int SQ_W = 2 * DATA_W - 1;

  // A square never exceeds 2^(2*DATA_W-2), so a (2*DATA_W-1)-bit product is exact.
  logic signed [SQ_W-1:0] w_re_ext;
  logic signed [SQ_W-1:0] w_im_ext;
  logic signed [SQ_W-1:0] w_re_prod;
  logic signed [SQ_W-1:0] w_im_prod;
  logic [MAG_W-1:0]       w_sum;

  logic [SQ_W-1:0]   r_re_sq;
  logic [SQ_W-1:0]   r_im_sq;
  logic              r_v1;
  logic [ADDR_W-1:0] r_idx1;
  logic              r_v2;
  logic [ADDR_W-1:0] r_idx2;
  logic [MAG_W-1:0]  r_mag;

  assign w_re_ext  = {{(DATA_W-1){i_re[DATA_W-1]}}, i_re};
  assign w_im_ext  = {{(DATA_W-1){i_im[DATA_W-1]}}, i_im};
  assign w_re_prod = w_re_ext * w_re_ext;
  assign w_im_prod = w_im_ext * w_im_ext;
  assign w_sum     = {{(MAG_W-SQ_W){1'b0}}, r_re_sq} + {{(MAG_W-SQ_W){1'b0}}, r_im_sq};

  // Pipeline registers for both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_re_sq <= '0;
      r_im_sq <= '0;
      r_v1    <= 1'b0;
      r_idx1  <= '0;
      r_v2    <= 1'b0;
      r_idx2  <= '0;
      r_mag   <= '0;
    end else begin
      r_re_sq <= $unsigned(w_re_prod);
      r_im_sq <= $unsigned(w_im_prod);
      r_v1    <= i_valid;
      r_idx1  <= i_idx;
      r_v2    <= r_v1;
      r_idx2  <= r_idx1;
      r_mag   <= w_sum;
    end
  end

  assign o_s1_valid = r_v1;
  assign o_valid    = r_v2;
  assign o_idx      = r_idx2;
  assign o_mag      = r_mag;

endmodule

// File: rtl/fft_mag_store.sv
// Captures one FFT frame after an fft_valid rising edge, writes |X|^2 per bin to RAM
// and pulses fft_shutdown when done. Peak tracker is built only with FFT_MAG_PEAK_EN.
module fft_mag_store
  import fft_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = $clog2(N_POINTS),
  parameter int MAG_W    = mag_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fft_valid,
  input  logic [DATA_W-1:0] i_s_re,
  input  logic [DATA_W-1:0] i_s_im,
  input  logic              i_s_tvalid,
  input  logic              i_s_tlast,
  output logic              o_s_tready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [MAG_W-1:0]  o_ram_wdata,
  output logic              o_fft_shutdown,
  output logic              o_frame_err,
  output logic [ADDR_W-1:0] o_peak_addr,
  output logic [MAG_W-1:0]  o_peak_mag
);

  state_t            r_state;
  logic              r_fv_d;
  logic              r_armed;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_tready;
  logic              r_shutdown;
  logic              r_frame_err;

  logic              w_hs;
  logic              w_is_last;
  logic              w_start;
  logic              w_s1_valid;
  logic              w_pipe_valid;
  logic [ADDR_W-1:0] w_pipe_idx;
  logic [MAG_W-1:0]  w_pipe_mag;

  assign w_hs      = i_s_tvalid & r_tready;
  assign w_is_last = (r_cnt == ADDR_W'(N_POINTS - 1));
  // The first sampled level after reset only primes the edge detector, so a
  // level held high across reset is not mistaken for a new edge.
  assign w_start   = (r_state == ST_IDLE) & r_armed & i_fft_valid & ~r_fv_d;

  fft_mag_sq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MAG_W  (MAG_W)
  ) u_mag_sq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (w_hs),
    .i_re       (i_s_re),
    .i_im       (i_s_im),
    .i_idx      (r_cnt),
    .o_s1_valid (w_s1_valid),
    .o_valid    (w_pipe_valid),
    .o_idx      (w_pipe_idx),
    .o_mag      (w_pipe_mag)
  );

  // Control FSM with bin counter, tlast check and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fv_d      <= 1'b0;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_tready    <= 1'b0;
      r_shutdown  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_fv_d  <= i_fft_valid;
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_shutdown <= 1'b0;
          if (w_start) begin
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
            r_tready    <= 1'b1;
            r_state     <= ST_CAPTURE;
          end else begin
            r_tready <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (w_hs) begin
            r_cnt <= r_cnt + ADDR_W'(1);
            if (i_s_tlast != w_is_last) begin
              r_frame_err <= 1'b1;
            end
            if (w_is_last) begin
              r_tready <= 1'b0;
              r_state  <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Stage 1 empty means the last write retires on this edge.
          if (!w_s1_valid) begin
            r_shutdown <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_shutdown <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_tready   <= 1'b0;
          r_shutdown <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_s_tready     = r_tready;
  assign o_fft_shutdown = r_shutdown;
  assign o_frame_err    = r_frame_err;
  assign o_ram_we       = w_pipe_valid;
  assign o_ram_addr     = w_pipe_idx;
  assign o_ram_wdata    = w_pipe_mag;

`ifdef FFT_MAG_PEAK_EN
  logic [ADDR_W-1:0] r_peak_addr;
  logic [MAG_W-1:0]  r_peak_mag;
  logic              w_cand;

  // DC and the mirrored upper half are not candidates.
  assign w_cand = w_pipe_valid & (w_pipe_idx != '0) & (w_pipe_idx < ADDR_W'(N_POINTS / 2));

  // Peak tracker; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_addr <= '0;
      r_peak_mag  <= '0;
    end else if (w_start) begin
      r_peak_addr <= '0;
      r_peak_mag  <= '0;
    end else if (w_cand && (w_pipe_mag > r_peak_mag)) begin
      r_peak_addr <= w_pipe_idx;
      r_peak_mag  <= w_pipe_mag;
    end else begin
      r_peak_addr <= r_peak_addr;
      r_peak_mag  <= r_peak_mag;
    end
  end

  assign o_peak_addr = r_peak_addr;
  assign o_peak_mag  = r_peak_mag;
`else
  assign o_peak_addr = '0;
  assign o_peak_mag  = '0;
`endif

endmodule

// File: tb/tb_fft_mag_store.sv
// Self-checking bench for fft_mag_store (N_POINTS=8, DATA_W=16): table frames,
// randomized frames against a plain-arithmetic model, and reset/retrigger sequences.
module tb_fft_mag_store;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int MW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fft_valid = 1'b0;
  logic [DW-1:0] s_re = '0;
  logic [DW-1:0] s_im = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready, ram_we, fft_shutdown, frame_err;
  logic [AW-1:0] ram_addr, peak_addr;
  logic [MW-1:0] ram_wdata, peak_mag;

  always #5 clk = ~clk;

  fft_mag_store #(.N_POINTS(N), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fft_valid    (fft_valid),
    .i_s_re         (s_re),
    .i_s_im         (s_im),
    .i_s_tvalid     (s_tvalid),
    .i_s_tlast      (s_tlast),
    .o_s_tready     (s_tready),
    .o_ram_we       (ram_we),
    .o_ram_addr     (ram_addr),
    .o_ram_wdata    (ram_wdata),
    .o_fft_shutdown (fft_shutdown),
    .o_frame_err    (frame_err),
    .o_peak_addr    (peak_addr),
    .o_peak_mag     (peak_mag)
  );

  typedef struct {
    int     re;
    int     im;
    longint mag;
  } bin_t;

  typedef struct {
    int   set_id;
    int   stall;
    int   tlast_at;
    logic exp_err;
  } cfg_t;

  bin_t   t_norm[N], t_ext[N], t_peak[N];
  cfg_t   cfgs[6];
  int     fr_re[N], fr_im[N];
  longint exp_mag[N];
  int     tlast_at, stall_mode;

  int     n_err = 0, n_chk = 0, cyc = 0;
  int     hs_q[$], wr_cyc_q[$], wr_addr_q[$], sd_q[$];
  longint wr_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle: handshakes, RAM writes, shutdown pulses.
  always @(negedge clk) begin
    if (s_tvalid && s_tready) hs_q.push_back(cyc);
    if (ram_we) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(int'(ram_addr));
      wr_data_q.push_back(longint'(ram_wdata));
    end
    if (fft_shutdown) sd_q.push_back(cyc);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ref_mag(input int re, input int im);
    return longint'(re) * longint'(re) + longint'(im) * longint'(im);
  endfunction

  task automatic clear_logs();
    hs_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); sd_q.delete();
  endtask

  task automatic load_set(input int id);
    for (int k = 0; k < N; k++) begin
      case (id)
        0: begin fr_re[k] = t_norm[k].re; fr_im[k] = t_norm[k].im; exp_mag[k] = t_norm[k].mag; end
        1: begin fr_re[k] = t_ext[k].re;  fr_im[k] = t_ext[k].im;  exp_mag[k] = t_ext[k].mag;  end
        default: begin fr_re[k] = t_peak[k].re; fr_im[k] = t_peak[k].im; exp_mag[k] = t_peak[k].mag; end
      endcase
    end
  endtask

  task automatic send_frame();
    int  k, guard;
    logic hs;
    clear_logs();
    @(posedge clk); #1 fft_valid = 1'b0;
    @(posedge clk); #1 fft_valid = 1'b1;
    k = 0; guard = 0;
    while (k < N && guard < 400) begin
      case (stall_mode)
        0:       s_tvalid = 1'b1;
        1:       s_tvalid = (guard % 2 == 1);
        default: s_tvalid = 1'(($urandom_range(0, 1)));
      endcase
      s_re    = DW'(fr_re[k]);
      s_im    = DW'(fr_im[k]);
      s_tlast = (k == tlast_at);
      @(negedge clk); hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (k < N) chk("hs_timeout", k, N);
    guard = 0;
    while (sd_q.size() == 0 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    repeat (3) @(posedge clk);
    #1 fft_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic exp_err);
    int     pa;
    longint pm;
    chk({tag, "_hs_count"}, hs_q.size(), N);
    chk({tag, "_wr_count"}, wr_addr_q.size(), N);
    for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_mag[i]);
      if (i < hs_q.size()) chk($sformatf("%s_wrlat%0d", tag, i), wr_cyc_q[i] - hs_q[i], 2);
    end
    chk({tag, "_sd_count"}, sd_q.size(), 1);
    if (sd_q.size() > 0 && hs_q.size() >= N) chk({tag, "_sd_lat"}, sd_q[0] - hs_q[N-1], 3);
    chk({tag, "_frame_err"}, frame_err, exp_err);
    pa = 0; pm = 0;
`ifdef FFT_MAG_PEAK_EN
    for (int k = 1; k < N / 2; k++) begin
      if (exp_mag[k] > pm) begin pm = exp_mag[k]; pa = k; end
    end
`endif
    chk({tag, "_peak_addr"}, peak_addr, pa);
    chk({tag, "_peak_mag"}, peak_mag, pm);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tready"}, s_tready, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_sd"}, fft_shutdown, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_paddr"}, peak_addr, 0);
    chk({tag, "_pmag"}, peak_mag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, guard;
    for (int i = 0; i < N; i++) begin
      t_norm[i] = '{i, -i, longint'(2 * i * i)};
      t_ext[i]  = t_norm[i];
    end
    t_ext[2] = '{-32768, -32768, 64'h8000_0000};
    t_ext[5] = '{32767, -32768, 64'h7FFF_0001};
    t_peak[0] = '{20, 10, 500};  t_peak[1] = '{3, 1, 10};
    t_peak[2] = '{6, 2, 40};     t_peak[3] = '{2, 6, 40};
    t_peak[4] = '{3, 0, 9};      t_peak[5] = '{30, 0, 900};
    t_peak[6] = '{0, -30, 900};  t_peak[7] = '{-30, 0, 900};
    cfgs[0] = '{0, 0, 7, 1'b0};
    cfgs[1] = '{0, 1, 7, 1'b0};
    cfgs[2] = '{1, 0, 7, 1'b0};
    cfgs[3] = '{0, 0, 3, 1'b1};
    cfgs[4] = '{0, 0, 7, 1'b0};
    cfgs[5] = '{2, 2, 7, 1'b0};

    #2 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 6; c++) begin
      load_set(cfgs[c].set_id);
      stall_mode = cfgs[c].stall;
      tlast_at   = cfgs[c].tlast_at;
      send_frame();
      check_frame($sformatf("cfg%0d", c), cfgs[c].exp_err);
    end
`ifdef FFT_MAG_PEAK_EN
    chk("peak_tab_addr", peak_addr, 2);
    chk("peak_tab_mag", peak_mag, 40);
`endif

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        fr_re[i]   = $urandom_range(0, 65535) - 32768;
        fr_im[i]   = $urandom_range(0, 65535) - 32768;
        exp_mag[i] = ref_mag(fr_re[i], fr_im[i]);
      end
      stall_mode = 2;
      tlast_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N)) : N - 1;
      send_frame();
      check_frame($sformatf("rnd%0d", r), tlast_at != N - 1);
    end

    // Reset after bin 4 with fft_valid still high, then retrigger on a fresh edge.
    load_set(0);
    clear_logs();
    @(posedge clk); #1 fft_valid = 1'b1;
    k = 0; guard = 0;
    while (k < 5 && guard < 50) begin
      s_tvalid = 1'b1; s_re = DW'(fr_re[k]); s_im = DW'(fr_im[k]); s_tlast = 1'b0;
      @(posedge clk); #1;
      k = hs_q.size(); guard++;
    end
    chk("rst_hs_before", k, 5);
    rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    clear_logs();
    repeat (10) @(posedge clk);
    #1;
    chk("held_hs", hs_q.size(), 0);
    chk("held_wr", wr_addr_q.size(), 0);
    chk("held_sd", sd_q.size(), 0);
    chk("held_tready", s_tready, 0);
    s_tvalid = 1'b0;
    stall_mode = 0; tlast_at = 7;
    send_frame();
    check_frame("retrig", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
